radar_sweep_sequencer: RTL and testbench

- Central scheduler for the radar. It steps the servo through N_BINS angle bins in a ping-pong sweep and waits for mechanical settle at each bin.
- At each bin it fires one HC-SR04 trigger pulse, times the echo with a timeout, and emits one distance result per bin.
- It owns the servo setpoint, sensor trigger and bin index, so the PWM generator, dot-matrix display and speaker consume its outputs instead of free-running independently.

---
 rtl/radar_sweep_sequencer_if.sv | 23 ++
 rtl/radar_sweep_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_radar_sweep_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/radar_sweep_sequencer_if.sv
// rtl/radar_sweep_sequencer_if.sv - sensor, servo and result signals of the radar sweep sequencer
interface radar_sweep_sequencer_if;
    logic        en;
    logic        ech;
    logic        tk;
    logic [19:0] servo_sp;
    logic [3:0]  bin;
    logic        dir;
    logic        dist_valid;
    logic [6:0]  dist_cm;
    logic        timeout;
    logic        busy;

    modport master (
        input  en, ech,
        output tk, servo_sp, bin, dir, dist_valid, dist_cm, timeout, busy
    );

    modport slave (
        output en, ech,
        input  tk, servo_sp, bin, dir, dist_valid, dist_cm, timeout, busy
    );
endinterface

// File: rtl/radar_sweep_sequencer.sv
// rtl/radar_sweep_sequencer.sv - ping-pong servo sweep with one HC-SR04 ping and distance result per bin
// Optional macro RADAR_RETRY_EN: retry a timed-out ping once at the same bin before reporting.
module radar_sweep_sequencer #(
    parameter int N_BINS           = 7,
    parameter int SP_MIN           = 16000,
    parameter int SP_STEP          = 8333,
    parameter int SETTLE_CYC       = 2700000,
    parameter int TRIG_CYC         = 270,
    parameter int RISE_TIMEOUT_CYC = 810000,
    parameter int CYC_PER_CM       = 1562,
    parameter int MIN_GAP_CYC      = 1620000
) (
    input  logic clk,
    input  logic rst,
    radar_sweep_sequencer_if.master bus
);
    localparam int TMR_MAX = (SETTLE_CYC > RISE_TIMEOUT_CYC)
                           ? ((SETTLE_CYC > TRIG_CYC) ? SETTLE_CYC : TRIG_CYC)
                           : ((RISE_TIMEOUT_CYC > TRIG_CYC) ? RISE_TIMEOUT_CYC : TRIG_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int GAP_W = $clog2(MIN_GAP_CYC + 1);
    localparam int SUB_W = $clog2(CYC_PER_CM + 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, TRIG, WAIT_RISE, MEASURE, REPORT, STEP
    } state_t;

    state_t           state, state_n;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic [GAP_W-1:0] gap_cnt;
    logic [SUB_W-1:0] sub_cnt, sub_n;
    logic [6:0]       cm_cnt, cm_n;
    logic             ech_meta, ech_sync, ech_prev;
    logic             ech_rise, ech_fall, gap_ok;
    logic             ping_timeout, load_res, step;
    logic [6:0]       res_cm_n;
    logic             res_to_n;
    logic [3:0]       bin_q, bin_n;
    logic             dir_q, dir_n;
    logic [19:0]      sp_q;
    logic             tk_q, dv_q, to_q;
    logic [6:0]       cm_q;
`ifdef RADAR_RETRY_EN
    logic             retried, retried_n;
`endif

    assign ech_rise = ech_sync & ~ech_prev;
    assign ech_fall = ~ech_sync & ech_prev;
    assign gap_ok   = (gap_cnt >= GAP_W'(MIN_GAP_CYC - 1));

    always_comb begin
        state_n      = state;
        tmr_n        = tmr;
        sub_n        = sub_cnt;
        cm_n         = cm_cnt;
        ping_timeout = 1'b0;
        load_res     = 1'b0;
        res_cm_n     = cm_q;
        res_to_n     = to_q;
        step         = 1'b0;
`ifdef RADAR_RETRY_EN
        retried_n    = retried;
`endif
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = SETTLE;
                    tmr_n   = '0;
                end
            end
            SETTLE: begin
                // settle counter saturates so a gap-limited wait keeps it satisfied
                if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
                    if (gap_ok) begin
                        state_n = TRIG;
                        tmr_n   = '0;
                    end
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            TRIG: begin
                if (tmr == TMR_W'(TRIG_CYC - 1)) begin
                    state_n = WAIT_RISE;
                    tmr_n   = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (ech_rise) begin
                    state_n = MEASURE;
                    sub_n   = '0;
                    cm_n    = '0;
                end else if (tmr == TMR_W'(RISE_TIMEOUT_CYC - 1)) begin
                    ping_timeout = 1'b1;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            MEASURE: begin
                if (ech_fall) begin
                    state_n  = REPORT;
                    load_res = 1'b1;
                    res_cm_n = cm_cnt;
                    res_to_n = 1'b0;
                end else if (cm_cnt == 7'd127) begin
                    ping_timeout = 1'b1;
                end else if (sub_cnt == SUB_W'(CYC_PER_CM - 1)) begin
                    sub_n = '0;
                    cm_n  = cm_cnt + 7'd1;
                end else begin
                    sub_n = sub_cnt + 1'b1;
                end
            end
            REPORT: begin
                state_n = STEP;
            end
            STEP: begin
                step    = 1'b1;
                tmr_n   = '0;
                state_n = bus.en ? SETTLE : IDLE;
`ifdef RADAR_RETRY_EN
                retried_n = 1'b0;
`endif
            end
            default: state_n = IDLE;
        endcase

        if (ping_timeout) begin
`ifdef RADAR_RETRY_EN
            if (!retried) begin
                // re-enter SETTLE already satisfied so only the trigger gap is honoured
                state_n   = SETTLE;
                tmr_n     = TMR_W'(SETTLE_CYC - 1);
                retried_n = 1'b1;
            end else begin
                state_n  = REPORT;
                load_res = 1'b1;
                res_cm_n = 7'd127;
                res_to_n = 1'b1;
            end
`else
            state_n  = REPORT;
            load_res = 1'b1;
            res_cm_n = 7'd127;
            res_to_n = 1'b1;
`endif
        end
    end

    always_comb begin
        bin_n = bin_q;
        dir_n = dir_q;
        if (!dir_q) begin
            if (bin_q == 4'(N_BINS - 1)) begin
                dir_n = 1'b1;
                bin_n = bin_q - 4'd1;
            end else begin
                bin_n = bin_q + 4'd1;
            end
        end else begin
            if (bin_q == 4'd0) begin
                dir_n = 1'b0;
                bin_n = 4'd1;
            end else begin
                bin_n = bin_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            sub_cnt  <= '0;
            cm_cnt   <= '0;
            gap_cnt  <= GAP_W'(MIN_GAP_CYC);
            ech_meta <= 1'b0;
            ech_sync <= 1'b0;
            ech_prev <= 1'b0;
            tk_q     <= 1'b0;
            dv_q     <= 1'b0;
            cm_q     <= '0;
            to_q     <= 1'b0;
            bin_q    <= '0;
            dir_q    <= 1'b0;
            sp_q     <= 20'(SP_MIN);
`ifdef RADAR_RETRY_EN
            retried  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            sub_cnt  <= sub_n;
            cm_cnt   <= cm_n;
            ech_meta <= bus.ech;
            ech_sync <= ech_meta;
            ech_prev <= ech_sync;
            tk_q     <= (state_n == TRIG);
            dv_q     <= (state_n == REPORT);
`ifdef RADAR_RETRY_EN
            retried  <= retried_n;
`endif
            // gap is measured from the trigger rise, i.e. the first TRIG cycle
            if (state == TRIG && tmr == '0)
                gap_cnt <= GAP_W'(1);
            else if (gap_cnt != GAP_W'(MIN_GAP_CYC))
                gap_cnt <= gap_cnt + 1'b1;
            if (load_res) begin
                cm_q <= res_cm_n;
                to_q <= res_to_n;
            end
            if (step) begin
                bin_q <= bin_n;
                dir_q <= dir_n;
                sp_q  <= 20'(SP_MIN + int'(bin_n) * SP_STEP);
            end
        end
    end

    assign bus.tk         = tk_q;
    assign bus.servo_sp   = sp_q;
    assign bus.bin        = bin_q;
    assign bus.dir        = dir_q;
    assign bus.dist_valid = dv_q;
    assign bus.dist_cm    = cm_q;
    assign bus.timeout    = to_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_radar_sweep_sequencer.sv
// tb/tb_radar_sweep_sequencer.sv - directed bench for radar_sweep_sequencer with a small sensor model
module tb_radar_sweep_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rises = 0;
    logic tk_prev = 1'b0;

`ifdef RADAR_RETRY_EN
    localparam int RETRY = 1;
`else
    localparam int RETRY = 0;
`endif

    radar_sweep_sequencer_if bus_if();

    radar_sweep_sequencer #(
        .N_BINS(3), .SP_MIN(16000), .SP_STEP(8333), .SETTLE_CYC(10), .TRIG_CYC(4),
        .RISE_TIMEOUT_CYC(50), .CYC_PER_CM(8), .MIN_GAP_CYC(40)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        tk_prev <= bus_if.tk;
        if (bus_if.tk && !tk_prev) rises <= rises + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: echo pulse, 1: no echo, 2: echo held, 3: stale echo then fresh pulse, 4: pulse with en dropped
    task automatic ping(input string tag, input int mode, input int len,
                        input int exp_cm, input int exp_to, input int exp_bin,
                        input int exp_dir, input int exp_sp, output int rise_cyc);
        int n;
        int w;
        int r0;
        r0 = rises;
        n  = 0;
        while (!bus_if.tk && n < 5000) begin
            @(negedge clk);
            n++;
        end
        rise_cyc = cyc;
        if (!bus_if.tk) begin
            check_eq({tag, "_tk_rise"}, 0, 1);
            return;
        end
        if (mode == 3) bus_if.ech = 1'b1;
        w = 0;
        while (bus_if.tk && w < 100) begin
            w++;
            @(negedge clk);
        end
        check_eq({tag, "_tk_width"}, w, 4);
        case (mode)
            0: begin
                bus_if.ech = 1'b1;
                repeat (len) @(negedge clk);
                bus_if.ech = 1'b0;
            end
            2: bus_if.ech = 1'b1;
            3: begin
                repeat (5) @(negedge clk);
                bus_if.ech = 1'b0;
                repeat (5) @(negedge clk);
                bus_if.ech = 1'b1;
                repeat (len) @(negedge clk);
                bus_if.ech = 1'b0;
            end
            4: begin
                bus_if.ech = 1'b1;
                repeat (10) @(negedge clk);
                bus_if.en = 1'b0;
                repeat (len - 10) @(negedge clk);
                bus_if.ech = 1'b0;
            end
            default: ;
        endcase
        n = 0;
        while (!bus_if.dist_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_dist_valid"}, int'(bus_if.dist_valid), 1);
        check_eq({tag, "_dist_cm"}, int'(bus_if.dist_cm), exp_cm);
        check_eq({tag, "_timeout"}, int'(bus_if.timeout), exp_to);
        check_eq({tag, "_bin"}, int'(bus_if.bin), exp_bin);
        check_eq({tag, "_dir"}, int'(bus_if.dir), exp_dir);
        check_eq({tag, "_servo_sp"}, int'(bus_if.servo_sp), exp_sp);
        check_eq({tag, "_tk_pulses"}, rises - r0, (exp_to != 0 && RETRY != 0) ? 2 : 1);
        if (mode == 2) bus_if.ech = 1'b0;
        @(negedge clk);
        check_eq({tag, "_dv_single"}, int'(bus_if.dist_valid), 0);
        check_eq({tag, "_cm_hold"}, int'(bus_if.dist_cm), exp_cm);
    endtask

    initial begin
        int c0;
        int r1;
        int r2;
        bus_if.en  = 1'b0;
        bus_if.ech = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tk", int'(bus_if.tk), 0);
        check_eq("rst_servo_sp", int'(bus_if.servo_sp), 16000);
        check_eq("rst_bin", int'(bus_if.bin), 0);
        check_eq("rst_dir", int'(bus_if.dir), 0);
        check_eq("rst_dist_valid", int'(bus_if.dist_valid), 0);
        check_eq("rst_dist_cm", int'(bus_if.dist_cm), 0);
        check_eq("rst_timeout", int'(bus_if.timeout), 0);
        check_eq("rst_busy", int'(bus_if.busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", int'(bus_if.busy), 0);

        bus_if.en = 1'b1;
        c0 = cyc;
        ping("p1", 0, 85, 10, 0, 0, 0, 16000, r1);
        check_eq("p1_latency", r1 - c0, 11);
        ping("p2", 0, 17, 2, 0, 1, 0, 24333, r1);
        ping("p3", 1, 0, 127, 1, 2, 0, 32666, r2);
        check_eq("p3_gap", r2 - r1, 40);
        ping("p4", 2, 0, 127, 1, 1, 1, 24333, r1);
        ping("p5", 4, 85, 10, 0, 0, 1, 16000, r1);
        repeat (2) @(negedge clk);
        check_eq("p5_idle_busy", int'(bus_if.busy), 0);
        check_eq("p5_idle_bin", int'(bus_if.bin), 1);
        check_eq("p5_idle_dir", int'(bus_if.dir), 0);
        check_eq("p5_idle_sp", int'(bus_if.servo_sp), 24333);
        repeat (20) @(negedge clk);
        check_eq("p5_still_idle", int'(bus_if.busy), 0);
        check_eq("p5_no_tk", int'(bus_if.tk), 0);

        bus_if.en = 1'b1;
        ping("p6", 3, 29, 3, 0, 1, 0, 24333, r1);

        c0 = 0;
        while (!bus_if.tk && c0 < 5000) begin
            @(negedge clk);
            c0++;
        end
        check_eq("p7_tk_seen", int'(bus_if.tk), 1);
        check_eq("p7_bin", int'(bus_if.bin), 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_tk", int'(bus_if.tk), 0);
        check_eq("mid_rst_busy", int'(bus_if.busy), 0);
        check_eq("mid_rst_bin", int'(bus_if.bin), 0);
        check_eq("mid_rst_dir", int'(bus_if.dir), 0);
        check_eq("mid_rst_sp", int'(bus_if.servo_sp), 16000);
        check_eq("mid_rst_cm", int'(bus_if.dist_cm), 0);
        check_eq("mid_rst_timeout", int'(bus_if.timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        ping("p8", 0, 17, 2, 0, 0, 0, 16000, r1);
        check_eq("p8_no_gap_delay", r1 - c0, 11);

        bus_if.en = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
